// File: rtl/out_display_ctrl.sv
// Output-register display: sequential double-dabble binary-to-BCD conversion
// feeding a time-multiplexed, active-low-anode 3-digit seven-segment display.
module out_display_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  value,
    input  logic        load,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    // Request protocol: load is a fire-and-forget strobe with no ready. A load
    // seen while busy lands in a single pending slot (newest value wins) and is
    // converted right after the current one; done pulses once per bcd update.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

    state_t      state;
    logic [19:0] sr;
    logic [2:0]  cnt;
    logic        pend;
    logic [7:0]  pend_val;

    logic [15:0] presc;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg_next;
    logic [2:0]  an_next;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
            bcd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sr    <= {12'b0, value};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end else if (pend) begin
                        sr    <= {12'b0, pend_val};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= dabble_step(sr);
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                    end
                    if (load) begin
                        pend     <= 1'b1;
                        pend_val <= value;
                    end
                end
                DONE: begin
                    bcd  <= sr[19:8];
                    done <= 1'b1;
                    if (pend) begin
                        sr    <= {12'b0, pend_val};
                        cnt   <= '0;
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    // A load here is newer than the request just serviced.
                    if (load) begin
                        pend     <= 1'b1;
                        pend_val <= value;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        digit    = 4'd0;
        an_next  = 3'b110;
        case (idx_next)
            2'd1: begin
                digit   = bcd[7:4];
                an_next = 3'b101;
            end
            2'd2: begin
                digit   = bcd[11:8];
                an_next = 3'b011;
            end
            default: begin
                digit   = bcd[3:0];
                an_next = 3'b110;
            end
        endcase
        blank = 1'b0;
        if (BLANK_LZ) begin
            if (idx_next == 2'd2 && bcd[11:8] == 4'd0) begin
                blank = 1'b1;
            end
            if (idx_next == 2'd1 && bcd[11:4] == 8'd0) begin
                blank = 1'b1;
            end
        end
        seg_next = blank ? 7'b0000000 : glyph(digit);
    end

    // an/seg only move on the prescaler wrap, so a digit never tears mid-slot.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc <= '0;
            idx   <= '0;
            an    <= 3'b110;
            seg   <= 7'b0111111;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= idx_next;
            an    <= an_next;
            seg   <= seg_next;
        end else begin
            presc <= presc + 16'd1;
        end
    end

endmodule

// File: tb/tb_out_display_ctrl.sv
// Bench for out_display_ctrl: two instances (blanking on/off) checked every cycle
// against a timer/arithmetic model, plus directed scenarios with literal expectations.
module tb_out_display_ctrl;

    localparam int SA = 4;
    localparam bit BA = 1'b1;
    localparam int SB = 3;
    localparam bit BB = 1'b0;

    logic        clk;
    logic        clr;
    logic [7:0]  value;
    logic        load;
    logic [11:0] bcd_a, bcd_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  an_a, an_b;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    out_display_ctrl #(.SCAN_DIV(SA), .BLANK_LZ(BA)) dut_a (
        .clk(clk), .clr(clr), .value(value), .load(load),
        .bcd(bcd_a), .busy(busy_a), .done(done_a), .seg(seg_a), .an(an_a)
    );

    out_display_ctrl #(.SCAN_DIV(SB), .BLANK_LZ(BB)) dut_b (
        .clk(clk), .clr(clr), .value(value), .load(load),
        .bcd(bcd_b), .busy(busy_b), .done(done_b), .seg(seg_b), .an(an_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] glyph_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                   7'b1111111, 7'b1101111};

    int         k;
    int         m_left;
    logic [7:0] m_cur, m_pv;
    bit         m_pend;
    logic [11:0] m_bcd;
    bit         m_busy, m_done;
    logic [2:0] m_an_a, m_an_b;
    logic [6:0] m_seg_a, m_seg_b;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic disp(input logic [11:0] b, input int d, input bit blz,
                        output logic [2:0] an_o, output logic [6:0] seg_o);
        int h, t, dig;
        bit blank;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        dig = (d == 0) ? int'(b[3:0]) : (d == 1) ? t : h;
        blank = blz && ((d == 2 && h == 0) || (d == 1 && h == 0 && t == 0));
        seg_o = blank ? 7'b0 : glyph_tab[dig];
        an_o  = ~(3'b001 << d);
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            k = 0; m_left = 0; m_cur = '0; m_pv = '0; m_pend = 0;
            m_bcd = '0; m_busy = 0; m_done = 0;
            m_an_a = 3'b110; m_an_b = 3'b110;
            m_seg_a = 7'b0111111; m_seg_b = 7'b0111111;
        end else begin
            k++;
            // display uses the bcd held before this edge
            if (k % SA == 0) disp(m_bcd, (k / SA) % 3, BA, m_an_a, m_seg_a);
            if (k % SB == 0) disp(m_bcd, (k / SB) % 3, BB, m_an_b, m_seg_b);
            m_done = 0;
            if (m_left == 0) begin
                if (load) begin
                    m_cur = value; m_left = 9; m_pend = 0;
                end else if (m_pend) begin
                    m_cur = m_pv; m_left = 9; m_pend = 0;
                end
            end else if (m_left == 1) begin
                m_bcd = to_bcd(int'(m_cur));
                m_done = 1;
                if (m_pend) begin
                    m_cur = m_pv; m_pend = 0; m_left = 9;
                end else begin
                    m_left = 0;
                end
                if (load) begin m_pend = 1; m_pv = value; end
            end else begin
                m_left--;
                if (load) begin m_pend = 1; m_pv = value; end
            end
            m_busy = (m_left > 0);
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_bcd",  bcd_a,  m_bcd);
            chk("a_busy", busy_a, m_busy);
            chk("a_done", done_a, m_done);
            chk("a_an",   an_a,   m_an_a);
            chk("a_seg",  seg_a,  m_seg_a);
            chk("b_bcd",  bcd_b,  m_bcd);
            chk("b_busy", busy_b, m_busy);
            chk("b_done", done_b, m_done);
            chk("b_an",   an_b,   m_an_b);
            chk("b_seg",  seg_b,  m_seg_b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_load(input logic [7:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n, nd, g0, g1, g2;
        bit ok, found;
        logic [2:0] prev, seen;

        clr = 1'b1; load = 1'b0; value = '0;
        #3 clr = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rst_bcd",   bcd_a,  12'h000);
        chk("rst_busy",  busy_a, 1'b0);
        chk("rst_done",  done_a, 1'b0);
        chk("rst_an",    an_a,   3'b110);
        chk("rst_seg",   seg_a,  7'b0111111);
        chk("rst_seg_b", seg_b,  7'b0111111);

        // 255: busy for 9 cycles, done and bcd at E9
        pulse_load(8'd255);
        n = 0;
        for (int e = 0; e < 9; e++) begin
            if (busy_a) n++;
            @(posedge clk);
            #1;
        end
        chk("busy_len_255", n, 9);
        chk("done_e9",      done_a, 1'b1);
        chk("bcd_255",      bcd_a, 12'h255);
        chk("busy_e9",      busy_a, 1'b0);

        // pending: 100 at E0, 42 at E3, 99 at E5
        pulse_load(8'd100);
        nd = 0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 3) begin value = 8'd42; load = 1'b1; end
            else if (e == 5) begin value = 8'd99; load = 1'b1; end
            else load = 1'b0;
            @(posedge clk);
            #1;
            load = 1'b0;
            if (done_a) nd++;
            if (e == 9) begin
                chk("pend_done_e9",  done_a, 1'b1);
                chk("pend_bcd_100",  bcd_a,  12'h100);
            end
            if (e == 18) begin
                chk("pend_done_e18", done_a, 1'b1);
                chk("pend_bcd_099",  bcd_a,  12'h099);
            end
        end
        chk("pend_done_count", nd, 2);

        // reset in the middle of converting 200
        pulse_load(8'd200);
        repeat (4) @(posedge clk);
        #2 clr = 1'b0;
        #1;
        chk("abort_bcd",  bcd_a,  12'h000);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_done", done_a, 1'b0);
        chk("abort_an",   an_a,   3'b110);
        chk("abort_seg",  seg_a,  7'b0111111);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done_a || busy_a) nd++;
        end
        chk("abort_no_activity", nd, 0);

        // 7 with blanking, SCAN_DIV=4
        pulse_load(8'd7);
        wait_done(ok);
        chk("done_7_seen", ok, 1'b1);
        chk("bcd_7",       bcd_a, 12'h007);
        prev  = an_a;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (an_a == 3'b110 && prev != 3'b110) found = 1'b1;
            else prev = an_a;
        end
        chk("scan_start_found", found, 1'b1);
        g0 = 0; g1 = 0; g2 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 4  && an_a == 3'b110 && seg_a == 7'b0000111) g0++;
            if (i >= 4 && i < 8 && an_a == 3'b101 && seg_a == 7'b0000000) g1++;
            if (i >= 8 && an_a == 3'b011 && seg_a == 7'b0000000) g2++;
        end
        chk("scan7_ones", g0, 4);
        chk("scan7_tens", g1, 4);
        chk("scan7_hund", g2, 4);

        // 0 without blanking, SCAN_DIV=3
        pulse_load(8'd0);
        wait_done(ok);
        chk("done_0_seen", ok, 1'b1);
        chk("bcd_0",       bcd_b, 12'h000);
        repeat (3 * SB) @(negedge clk);
        n = 0; seen = '0;
        for (int i = 0; i < 3 * SB; i++) begin
            @(negedge clk);
            if (seg_b == 7'b0111111) n++;
            seen = seen | ~an_b;
        end
        chk("zero_all_glyph0", n, 3 * SB);
        chk("zero_all_digits", seen, 3'b111);

        // every input value, back to back
        nd = 0;
        for (int v = 0; v < 256; v++) begin
            pulse_load(8'(v));
            wait_done(ok);
            if (ok) nd++;
            chk("sweep_bcd", bcd_a, {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
        end
        chk("sweep_done_count", nd, 256);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
